// File: rtl/image_stream_source.sv
// Frame-buffer raster source: holds one frame in on-chip RAM and streams it row-major,
// one pixel per cycle, with optional horizontal blanking between lines.
module image_stream_source #(
  parameter int unsigned IMG_W      = 128,
  parameter int unsigned IMG_H      = 128,
  parameter int unsigned PIXEL_BITS = 8,
  parameter int unsigned HBLANK     = 0,
  parameter int unsigned ADDR_W     = $clog2(IMG_W * IMG_H)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_wr_en,
  input  logic [ADDR_W-1:0]     i_wr_addr,
  input  logic [PIXEL_BITS-1:0] i_wr_data,
  input  logic                  i_start,
  input  logic                  i_hold,
  output logic [PIXEL_BITS-1:0] o_pixel_out,
  output logic                  o_pixel_valid,
  output logic                  o_sol,
  output logic                  o_eol,
  output logic                  o_eof,
  output logic                  o_busy,
  output logic                  o_frame_done
);

  localparam int unsigned NPix   = IMG_W * IMG_H;
  localparam int unsigned ColW   = $clog2(IMG_W);
  localparam int unsigned RowW   = $clog2(IMG_H);
  localparam int unsigned BlankW = (HBLANK > 1) ? $clog2(HBLANK) : 1;

  localparam logic [ColW-1:0]   ColLast   = ColW'(IMG_W - 1);
  localparam logic [RowW-1:0]   RowLast   = RowW'(IMG_H - 1);
  localparam logic [BlankW-1:0] BlankLast = BlankW'((HBLANK > 0) ? HBLANK - 1 : 0);

  typedef enum logic [1:0] {StIdle, StStream, StBlank, StDone} state_e;

  state_e              r_state, w_state_next;
  logic [ColW-1:0]     r_col, w_col_next;
  logic [RowW-1:0]     r_row, w_row_next;
  logic [ADDR_W-1:0]   r_addr, w_addr_next;
  logic [BlankW-1:0]   r_blank, w_blank_next;
  logic                r_busy;
  logic                w_issue, w_start_acc, w_wr_ok;

  logic [PIXEL_BITS-1:0] r_mem [NPix];
  logic [PIXEL_BITS-1:0] r_rd_data;
  logic                  r_rd_vld, r_rd_sol, r_rd_eol, r_rd_eof;

  logic [PIXEL_BITS-1:0] r_pixel_out;
  logic                  r_pixel_valid, r_sol, r_eol, r_eof, r_frame_done;

  // Writes are blocked while streaming so the frame cannot change under the reader.
  assign w_wr_ok = i_wr_en && !r_busy && (32'(i_wr_addr) < NPix);

  always_comb begin
    w_state_next = r_state;
    w_col_next   = r_col;
    w_row_next   = r_row;
    w_addr_next  = r_addr;
    w_blank_next = r_blank;
    w_issue      = 1'b0;
    w_start_acc  = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (i_start && !r_busy) begin
          w_start_acc  = 1'b1;
          w_state_next = StStream;
          w_col_next   = '0;
          w_row_next   = '0;
          w_addr_next  = '0;
        end
      end
      StStream: begin
        if (!i_hold) begin
          w_issue     = 1'b1;
          w_addr_next = r_addr + ADDR_W'(1);
          if (r_col == ColLast) begin
            w_col_next = '0;
            w_row_next = r_row + RowW'(1);
            if (r_row == RowLast) begin
              w_state_next = StDone;
            end else if (HBLANK > 0) begin
              w_state_next = StBlank;
              w_blank_next = '0;
            end
          end else begin
            w_col_next = r_col + ColW'(1);
          end
        end
      end
      StBlank: begin
        if (r_blank == BlankLast) begin
          w_state_next = StStream;
        end else begin
          w_blank_next = r_blank + BlankW'(1);
        end
      end
      StDone:  w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
      r_col   <= '0;
      r_row   <= '0;
      r_addr  <= '0;
      r_blank <= '0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_col   <= w_col_next;
      r_row   <= w_row_next;
      r_addr  <= w_addr_next;
      r_blank <= w_blank_next;
      if (w_start_acc) begin
        r_busy <= 1'b1;
      end else if (r_frame_done) begin
        r_busy <= 1'b0;
      end
    end
  end

  // Frame RAM is deliberately not reset so a stored frame survives a stream abort.
  always_ff @(posedge clk) begin
    if (w_wr_ok) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
    if (w_issue) begin
      r_rd_data <= r_mem[r_addr];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_vld      <= 1'b0;
      r_rd_sol      <= 1'b0;
      r_rd_eol      <= 1'b0;
      r_rd_eof      <= 1'b0;
      r_pixel_out   <= '0;
      r_pixel_valid <= 1'b0;
      r_sol         <= 1'b0;
      r_eol         <= 1'b0;
      r_eof         <= 1'b0;
      r_frame_done  <= 1'b0;
    end else begin
      r_rd_vld      <= w_issue;
      r_rd_sol      <= w_issue && (r_col == '0);
      r_rd_eol      <= w_issue && (r_col == ColLast);
      r_rd_eof      <= w_issue && (r_col == ColLast) && (r_row == RowLast);
      r_pixel_valid <= r_rd_vld;
      r_sol         <= r_rd_sol;
      r_eol         <= r_rd_eol;
      r_eof         <= r_rd_eof;
      r_frame_done  <= r_rd_eof;
      if (r_rd_vld) begin
        r_pixel_out <= r_rd_data;
      end
    end
  end

  assign o_pixel_out   = r_pixel_out;
  assign o_pixel_valid = r_pixel_valid;
  assign o_sol         = r_sol;
  assign o_eol         = r_eol;
  assign o_eof         = r_eof;
  assign o_busy        = r_busy;
  assign o_frame_done  = r_frame_done;

endmodule

// File: tb/tb_image_stream_source.sv
// Bench for image_stream_source: two instances (no blanking, 2-cycle blanking) on shared
// stimulus, checked cycle by cycle against a schedule computed from the streaming rules.
module tb_image_stream_source;

  localparam int W    = 4;
  localparam int H    = 3;
  localparam int N    = W * H;
  localparam int AW   = 4;
  localparam int MAXK = 64;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          i_wr_en = 1'b0;
  logic [AW-1:0] i_wr_addr = '0;
  logic [7:0]    i_wr_data = '0;
  logic          i_start = 1'b0;
  logic          i_hold = 1'b0;

  logic [7:0] o0_pixel_out, o2_pixel_out;
  logic       o0_pixel_valid, o0_sol, o0_eol, o0_eof, o0_busy, o0_frame_done;
  logic       o2_pixel_valid, o2_sol, o2_eol, o2_eof, o2_busy, o2_frame_done;

  always #5 clk = ~clk;

  image_stream_source #(.IMG_W(W), .IMG_H(H), .PIXEL_BITS(8), .HBLANK(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .i_wr_en(i_wr_en), .i_wr_addr(i_wr_addr),
    .i_wr_data(i_wr_data), .i_start(i_start), .i_hold(i_hold),
    .o_pixel_out(o0_pixel_out), .o_pixel_valid(o0_pixel_valid), .o_sol(o0_sol),
    .o_eol(o0_eol), .o_eof(o0_eof), .o_busy(o0_busy), .o_frame_done(o0_frame_done)
  );

  image_stream_source #(.IMG_W(W), .IMG_H(H), .PIXEL_BITS(8), .HBLANK(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .i_wr_en(i_wr_en), .i_wr_addr(i_wr_addr),
    .i_wr_data(i_wr_data), .i_start(i_start), .i_hold(i_hold),
    .o_pixel_out(o2_pixel_out), .o_pixel_valid(o2_pixel_valid), .o_sol(o2_sol),
    .o_eol(o2_eol), .o_eof(o2_eof), .o_busy(o2_busy), .o_frame_done(o2_frame_done)
  );

  typedef struct {
    int hold_at;
    int hold_len;
    int exp_done0;
    int exp_done2;
  } vec_t;

  int         n_pass = 0;
  int         n_total = 0;
  logic [7:0] model_mem [N];
  logic [7:0] last_pix [2];
  int         hb_of [2];

  function automatic logic [13:0] act_vec(input int d);
    if (d == 0) begin
      return {o0_busy, o0_frame_done, o0_eof, o0_eol, o0_sol, o0_pixel_valid, o0_pixel_out};
    end
    return {o2_busy, o2_frame_done, o2_eof, o2_eol, o2_sol, o2_pixel_valid, o2_pixel_out};
  endfunction

  task automatic check(input string name, input int d, input logic [13:0] act,
                       input logic [13:0] exp);
    n_total++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s dut%0d: got busy,fd,eof,eol,sol,vld=%b pix=%h ; expected %b pix=%h",
               name, d, act[13:8], act[7:0], exp[13:8], exp[7:0]);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One idle cycle: both instances must be quiet; optionally write the frame RAM.
  task automatic idle_cycle(input string name, input bit wr, input logic [AW-1:0] addr,
                            input logic [7:0] data);
    @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      check(name, d, act_vec(d), {6'b000000, last_pix[d]});
    end
    i_start   = 1'b0;
    i_hold    = 1'b0;
    i_wr_en   = wr;
    i_wr_addr = addr;
    i_wr_data = data;
    if (wr && (addr < N)) model_mem[addr] = data;
  endtask

  // Stream one frame. Cycle 0 carries start; pixel i issued in cycle k is visible in k+2.
  task automatic run_frame(input string name, input logic [MAXK-1:0] hp, input int restart_k,
                           input int busy_wr_k, input bit co_wr, input logic [AW-1:0] co_addr,
                           input logic [7:0] co_data, output int obs0, output int obs2);
    int vis [2][MAXK];
    int done [2];
    int last;
    if (co_wr && (co_addr < N)) model_mem[co_addr] = co_data;
    for (int d = 0; d < 2; d++) begin
      int k = 1;
      int i = 0;
      for (int j = 0; j < MAXK; j++) vis[d][j] = -1;
      done[d] = MAXK - 1;
      while (i < N && k < MAXK - 2) begin
        if (hp[k]) begin
          k++;
        end else begin
          vis[d][k+2] = i;
          if (i == N - 1) done[d] = k + 2;
          i++;
          k++;
          if ((i % W) == 0 && i < N) k += hb_of[d];
        end
      end
    end
    last = (done[0] > done[1]) ? done[0] : done[1];
    obs0 = -1;
    obs2 = -1;
    for (int k = 0; k <= last; k++) begin
      @(posedge clk);
      #1;
      for (int d = 0; d < 2; d++) begin
        int         idx;
        logic [7:0] pix;
        bit         vld, sol, eol, eof, bsy;
        idx = vis[d][k];
        vld = (idx >= 0);
        pix = vld ? model_mem[idx] : last_pix[d];
        sol = vld && ((idx % W) == 0);
        eol = vld && ((idx % W) == W - 1);
        eof = vld && (idx == N - 1);
        bsy = (k >= 1) && (k <= done[d]);
        check(name, d, act_vec(d), {bsy, eof, eof, eol, sol, vld, pix});
        last_pix[d] = pix;
      end
      if (o0_frame_done && obs0 < 0) obs0 = k;
      if (o2_frame_done && obs2 < 0) obs2 = k;
      i_start = (k == 0) || (k == restart_k);
      i_hold  = hp[k];
      if (k == 0 && co_wr) begin
        i_wr_en = 1'b1; i_wr_addr = co_addr; i_wr_data = co_data;
      end else if (k == busy_wr_k) begin
        i_wr_en = 1'b1; i_wr_addr = '0; i_wr_data = 8'hFF;
      end else begin
        i_wr_en = 1'b0;
      end
    end
    i_start = 1'b0;
    i_hold  = 1'b0;
    i_wr_en = 1'b0;
  endtask

  initial begin
    vec_t            tbl [5];
    logic [MAXK-1:0] hp;
    int              o0, o2;
    bit              found;

    tbl = '{'{0, 0, 14, 18}, '{7, 3, 17, 21}, '{5, 2, 16, 18}, '{1, 1, 15, 19},
            '{14, 4, 14, 22}};
    hb_of[0] = 0;
    hb_of[1] = 2;
    last_pix[0] = '0;
    last_pix[1] = '0;

    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) check("reset_state", d, act_vec(d), 14'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < N; i++) idle_cycle("load", 1'b1, AW'(i), 8'(i));
    idle_cycle("oob_write", 1'b1, AW'(13), 8'hAA);

    // Table rows run back to back: each start lands the cycle after the previous frame ends.
    foreach (tbl[r]) begin
      hp = '0;
      for (int j = 0; j < tbl[r].hold_len; j++) hp[tbl[r].hold_at + j] = 1'b1;
      run_frame("table", hp, -1, -1, 1'b0, '0, '0, o0, o2);
      check_int($sformatf("table%0d_done0", r), o0, tbl[r].exp_done0);
      check_int($sformatf("table%0d_done2", r), o2, tbl[r].exp_done2);
    end

    // Restart and write attempts while busy must both be ignored.
    run_frame("busy_ignore", '0, 5, 6, 1'b0, '0, '0, o0, o2);
    check_int("busy_ignore_done0", o0, 14);
    run_frame("after_busy", '0, -1, -1, 1'b0, '0, '0, o0, o2);
    idle_cycle("idle", 1'b0, '0, '0);

    // Abort mid-frame with an asynchronous reset.
    @(posedge clk);
    #1;
    i_start = 1'b1;
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      @(posedge clk);
      #1;
      i_start = 1'b0;
      if (o0_pixel_valid && o0_pixel_out == model_mem[6]) found = 1'b1;
    end
    check_int("rst_pixel6_seen", int'(found), 1);
    #2;
    rst_n = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) check("async_reset", d, act_vec(d), 14'd0);
    repeat (3) begin
      @(posedge clk);
      #1;
      for (int d = 0; d < 2; d++) check("in_reset", d, act_vec(d), 14'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    last_pix[0] = '0;
    last_pix[1] = '0;
    run_frame("after_reset", '0, -1, -1, 1'b0, '0, '0, o0, o2);
    check_int("after_reset_done0", o0, 14);

    // Randomised holds, restarts, busy writes and write-with-start.
    for (int r = 0; r < 8; r++) begin
      hp = '0;
      for (int j = 1; j < 24; j++) hp[j] = ($urandom_range(3) == 0);
      run_frame("random", hp, ($urandom_range(1) != 0) ? int'($urandom_range(10, 1)) : -1,
                ($urandom_range(1) != 0) ? int'($urandom_range(10, 1)) : -1,
                ($urandom_range(1) != 0), AW'($urandom_range(15)), 8'($urandom), o0, o2);
      if ($urandom_range(1) != 0) begin
        idle_cycle("random_idle", 1'b1, AW'($urandom_range(15)), 8'($urandom));
        idle_cycle("random_idle", 1'b0, '0, '0);
      end
    end
    idle_cycle("final_idle", 1'b0, '0, '0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
